// File: rtl/xnor_prbs_checker.sv
// Purpose: self-synchronising receive checker for the XNOR PRBS7 law b[n] = ~(b[n-7] ^ b[n-6]).
// Latency: 1 cycle; every output reflects the valid bit sampled on the previous rising edge.
// Backpressure: none; in_valid qualifies each bit, and while it is low all state holds.
module xnor_prbs_checker #(
    parameter int LOCK_THRESH = 16,   // consecutive good predictions needed to lock (1..255)
    parameter int WINDOW      = 64,   // locked observation window in valid bits (2..256)
    parameter int LOSS_THRESH = 4,    // mismatches per window that drop lock (1..WINDOW)
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_bit,
    input  logic                 clr_cnt,
    output logic                 locked,
    output logic                 err_pulse,
    output logic                 lock_lost,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [7:0] MATCH_LAST = 8'(LOCK_THRESH);
    localparam logic [7:0] WIN_LAST   = 8'(WINDOW - 1);
    localparam logic [8:0] LOSS_LAST  = 9'(LOSS_THRESH);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [6:0]           hist_q, hist_d;      // hist_q[0] is the newest received bit
    logic [2:0]           fill_q, fill_d;      // saturates at 7 once the history is real data
    logic [7:0]           match_q, match_d;
    logic [7:0]           win_q, win_d;
    logic [8:0]           werr_q, werr_d;
    logic                 locked_q, locked_d;
    logic                 err_pulse_q, err_pulse_d;
    logic                 lock_lost_q, lock_lost_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                 exp_bit;
    logic                 mism;
    logic                 evaluated;
    logic                 win_last;
    logic [7:0]           match_inc;
    logic [8:0]           werr_base;
    logic [8:0]           werr_inc;

    // Prediction from the two oldest history taps, plus window bookkeeping helpers.
    always_comb begin
        exp_bit   = ~(hist_q[6] ^ hist_q[5]);
        mism      = in_bit ^ exp_bit;
        evaluated = (fill_q == 3'd7);
        match_inc = match_q + 8'd1;
        win_last  = (win_q == WIN_LAST);
        // A mismatch on the wrapping bit belongs to the new window.
        werr_base = win_last ? 9'd0 : werr_q;
        werr_inc  = werr_base + 9'd1;
    end

    // Next-state and registered-output logic for the SEARCH/LOCKED machine.
    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_d       = win_q;
        werr_d      = werr_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        lock_lost_d = 1'b0;
        err_cnt_d   = err_cnt_q;

        if (in_valid) begin
            hist_d = {hist_q[5:0], in_bit};
            if (!evaluated) begin
                fill_d = fill_q + 3'd1;
            end

            case (state_q)
                ST_SEARCH: begin
                    if (evaluated) begin
                        // All-ones history is the XNOR lock-up state; never count it as a match
                        // so that a stuck-high line cannot lock.
                        if (!mism && (hist_q != 7'h7F)) begin
                            match_d = match_inc;
                            if (match_inc == MATCH_LAST) begin
                                state_d  = ST_LOCKED;
                                locked_d = 1'b1;
                                win_d    = 8'd0;
                                werr_d   = 9'd0;
                            end
                        end else begin
                            match_d = 8'd0;
                        end
                    end
                end

                ST_LOCKED: begin
                    win_d  = win_last ? 8'd0 : (win_q + 8'd1);
                    werr_d = werr_base;
                    if (mism) begin
                        err_pulse_d = 1'b1;
                        werr_d      = werr_inc;
                        if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + ERR_ONE;
                        end
                        if (werr_inc == LOSS_LAST) begin
                            state_d     = ST_SEARCH;
                            locked_d    = 1'b0;
                            lock_lost_d = 1'b1;
                            match_d     = 8'd0;
                        end
                    end
                end

                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end

        // Clear wins over a same-cycle increment; the pulse for that mismatch still fires.
        if (clr_cnt) begin
            err_cnt_d = '0;
        end
    end

    // State and counter registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SEARCH;
            hist_q      <= 7'd0;
            fill_q      <= 3'd0;
            match_q     <= 8'd0;
            win_q       <= 8'd0;
            werr_q      <= 9'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            lock_lost_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_q       <= win_d;
            werr_q      <= werr_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            lock_lost_q <= lock_lost_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign lock_lost = lock_lost_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_xnor_prbs_checker.sv
// Purpose: directed self-checking bench for xnor_prbs_checker (default instance plus a saturation instance).
// Latency: outputs sampled 1 ns after the edge that captured each bit.
// Backpressure: none; stimulus drives in_valid directly.
module tb_xnor_prbs_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_bit, clr_cnt;
    logic        locked, err_pulse, lock_lost;
    logic [15:0] err_cnt;

    logic        in_valid2, in_bit2, clr_cnt2;
    logic        locked2, err_pulse2, lock_lost2;
    logic [15:0] err_cnt2;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [6:0]  g;
    logic [6:0]  g2;
    logic [6:0]  first7;
    logic        b2;
    logic        ever_locked, ever_pulse, sat_drop;

    always #5 clk = ~clk;

    xnor_prbs_checker #(
        .LOCK_THRESH (16),
        .WINDOW      (64),
        .LOSS_THRESH (4),
        .ERR_CNT_W   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .lock_lost (lock_lost),
        .err_cnt   (err_cnt)
    );

    xnor_prbs_checker #(
        .LOCK_THRESH (16),
        .WINDOW      (256),
        .LOSS_THRESH (256),
        .ERR_CNT_W   (16)
    ) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_bit    (in_bit2),
        .clr_cnt   (clr_cnt2),
        .locked    (locked2),
        .err_pulse (err_pulse2),
        .lock_lost (lock_lost2),
        .err_cnt   (err_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One valid bit from the generator model, optionally flipped on the wire.
    task automatic gen_bit(input logic flip, input logic clr);
        logic b;
        b        = ~(g[6] ^ g[5]);
        g        = {g[5:0], b};
        in_valid = 1'b1;
        in_bit   = b ^ flip;
        clr_cnt  = clr;
        @(posedge clk);
        #1;
        clr_cnt  = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_bit   = ~in_bit;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clr_cnt = 1'b0;
        in_valid2 = 1'b0; in_bit2 = 1'b0; clr_cnt2 = 1'b0;
        g = 7'h00; g2 = 7'h00; first7 = 7'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_locked", 32'(locked), 0);
        check("rst_err_pulse", 32'(err_pulse), 0);
        check("rst_lock_lost", 32'(lock_lost), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);

        // Clean acquisition, single-bit error, loss of lock, relock, clear-vs-increment.
        for (int i = 1; i <= 220; i++) begin
            gen_bit(i == 100 || i == 160 || i == 180 || i == 210, i == 150 || i == 216);
            if (i <= 7) first7 = {first7[5:0], in_bit};
            if (i >= 100 && i <= 107)
                check($sformatf("single_err_pulse_%0d", i), 32'(err_pulse),
                      32'(i == 100 || i == 106 || i == 107));
            case (i)
                7:   check("first_bits", 32'(first7), 32'h7E);
                22:  check("lock_not_yet", 32'(locked), 0);
                23:  begin
                         check("lock_at_23", 32'(locked), 1);
                         check("lock_err_cnt", 32'(err_cnt), 0);
                     end
                107: begin
                         check("single_err_cnt", 32'(err_cnt), 3);
                         check("single_err_locked", 32'(locked), 1);
                     end
                150: check("clr_cnt_idle", 32'(err_cnt), 0);
                179: begin
                         check("pre_loss_cnt", 32'(err_cnt), 3);
                         check("pre_loss_locked", 32'(locked), 1);
                         check("pre_loss_lost", 32'(lock_lost), 0);
                     end
                180: begin
                         check("loss_pulse", 32'(lock_lost), 1);
                         check("loss_locked", 32'(locked), 0);
                         check("loss_err_cnt", 32'(err_cnt), 4);
                     end
                181: check("loss_pulse_one_cycle", 32'(lock_lost), 0);
                186: check("search_no_pulse", 32'(err_pulse), 0);
                187: check("search_cnt_held", 32'(err_cnt), 4);
                202: check("relock_not_yet", 32'(locked), 0);
                203: check("relock", 32'(locked), 1);
                215: check("cnt_before_clr", 32'(err_cnt), 5);
                216: begin
                         check("clr_priority_cnt", 32'(err_cnt), 0);
                         check("clr_priority_pulse", 32'(err_pulse), 1);
                         check("clr_keeps_lock", 32'(locked), 1);
                     end
                217: check("cnt_after_clr", 32'(err_cnt), 1);
                default: ;
            endcase
        end

        // Asynchronous reset between edges while locked, then relock with gapped valid.
        idle_cycle();
        #3 rst = 1'b1;
        #1;
        check("async_rst_locked", 32'(locked), 0);
        check("async_rst_err_cnt", 32'(err_cnt), 0);
        check("async_rst_err_pulse", 32'(err_pulse), 0);
        check("async_rst_lock_lost", 32'(lock_lost), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        g = 7'h00;
        for (int k = 1; k <= 23; k++) begin
            gen_bit(1'b0, 1'b0);
            if (k == 22) check("gap_lock_not_yet", 32'(locked), 0);
            if (k == 23) check("gap_lock_at_23", 32'(locked), 1);
            idle_cycle();
        end
        check("gap_lock_holds_idle", 32'(locked), 1);
        check("gap_idle_no_pulse", 32'(err_pulse), 0);

        // Stuck-high line from reset must never lock.
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        ever_locked = 1'b0; ever_pulse = 1'b0;
        for (int k = 0; k < 200; k++) begin
            in_valid = 1'b1; in_bit = 1'b1;
            @(posedge clk);
            #1;
            ever_locked |= locked;
            ever_pulse  |= err_pulse;
        end
        in_valid = 1'b0;
        check("stuck1_never_locked", 32'(ever_locked), 0);
        check("stuck1_no_pulse", 32'(ever_pulse), 0);
        check("stuck1_err_cnt", 32'(err_cnt), 0);

        // Saturation: lock, then an inverted stream with a true bit every 128 so no window is all errors.
        for (int k = 1; k <= 23; k++) begin
            b2 = ~(g2[6] ^ g2[5]); g2 = {g2[5:0], b2};
            in_valid2 = 1'b1; in_bit2 = b2;
            @(posedge clk);
            #1;
        end
        check("sat_lock", 32'(locked2), 1);
        sat_drop = 1'b0;
        for (int k = 1; k <= 70000; k++) begin
            b2 = ~(g2[6] ^ g2[5]); g2 = {g2[5:0], b2};
            in_bit2 = ((k % 128) == 0) ? b2 : ~b2;
            @(posedge clk);
            #1;
            if (!locked2) sat_drop = 1'b1;
        end
        check("sat_never_dropped", 32'(sat_drop), 0);
        check("sat_err_cnt", 32'(err_cnt2), 32'hFFFF);
        for (int k = 0; k < 2; k++) begin
            b2 = ~(g2[6] ^ g2[5]); g2 = {g2[5:0], b2};
            in_bit2 = ~b2;
            @(posedge clk);
            #1;
            check($sformatf("sat_hold_pulse_%0d", k), 32'(err_pulse2), 1);
            check($sformatf("sat_hold_cnt_%0d", k), 32'(err_cnt2), 32'hFFFF);
        end
        in_valid2 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
